// File: rtl/load_store_unit.sv
// load_store_unit: memory-side initiator for the core's data path.
// Accepts one load/store at a time and drives a single-ported word memory
// with combinational read data. Byte stores are done as read-modify-write
// because the memory only has a word-wide write enable. Misaligned word
// accesses and addresses beyond the memory are completed as faults without
// touching memory.
//
// Handshake: a request is taken on a rising edge where req=1, the unit is
// idle (busy=0) and at least one edge has passed since reset released;
// a req seen while busy is dropped, not queued. Every accepted request ends
// with exactly one done pulse (unless reset aborts it), and rdata/fault are
// valid from the done cycle until the next accept (rdata only changes on a
// completed load).
module load_store_unit #(
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req,
    input  logic                 req_we,
    input  logic                 req_byte,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 busy,
    output logic                 done,
    output logic [31:0]          rdata,
    output logic                 fault,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [31:0]          mem_wdata,
    input  logic [31:0]          mem_rdata,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                r_state;
    logic                  r_armed;
    logic                  r_we;
    logic                  r_byte;
    logic [1:0]            r_lane;
    logic [7:0]            r_wbyte;
    logic                  r_busy;
    logic                  r_done;
    logic [31:0]           r_rdata;
    logic                  r_fault;
    logic                  r_mem_we;
    logic [ADDR_BITS-1:0]  r_mem_addr;
    logic [31:0]           r_mem_wdata;

    logic                  w_accept;
    logic                  w_misaligned;
    logic                  w_out_of_range;
    logic                  w_fault_in;
    logic [7:0]            w_rd_byte;
    logic [31:0]           w_merged;

    // Accept decode and fault classification of the incoming request.
    always_comb begin
        w_accept       = req && r_armed && (r_state == S_IDLE);
        w_misaligned   = !req_byte && (req_addr[1:0] != 2'b00);
        w_out_of_range = (req_addr >> ADDR_BITS) != 32'd0;
        w_fault_in     = w_misaligned || w_out_of_range;
    end

    // Byte-lane extraction for byte loads and lane merge for byte stores.
    always_comb begin
        w_rd_byte = 8'h00;
        w_merged  = mem_rdata;
        case (r_lane)
            2'd0: begin
                w_rd_byte      = mem_rdata[7:0];
                w_merged[7:0]  = r_wbyte;
            end
            2'd1: begin
                w_rd_byte      = mem_rdata[15:8];
                w_merged[15:8] = r_wbyte;
            end
            2'd2: begin
                w_rd_byte       = mem_rdata[23:16];
                w_merged[23:16] = r_wbyte;
            end
            default: begin
                w_rd_byte       = mem_rdata[31:24];
                w_merged[31:24] = r_wbyte;
            end
        endcase
    end

    // Request FSM with all outputs registered; r_armed blocks a req that
    // arrives in the cycle reset releases.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_armed     <= 1'b0;
            r_we        <= 1'b0;
            r_byte      <= 1'b0;
            r_lane      <= 2'd0;
            r_wbyte     <= 8'h00;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rdata     <= 32'd0;
            r_fault     <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'd0;
        end else begin
            r_armed <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we    <= req_we;
                        r_byte  <= req_byte;
                        r_lane  <= req_addr[1:0];
                        r_wbyte <= req_wdata[7:0];
                        r_fault <= 1'b0;
                        r_busy  <= 1'b1;
                        if (w_fault_in) begin
                            r_fault <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_RESP;
                        end else begin
                            r_mem_addr <= {req_addr[ADDR_BITS-1:2], 2'b00};
                            if (req_we && !req_byte) begin
                                r_mem_we    <= 1'b1;
                                r_mem_wdata <= req_wdata;
                                r_state     <= S_WRITE;
                            end else begin
                                r_state <= S_READ;
                            end
                        end
                    end
                end
                S_READ: begin
                    if (r_we) begin
                        r_mem_we    <= 1'b1;
                        r_mem_wdata <= w_merged;
                        r_state     <= S_WRITE;
                    end else begin
                        r_rdata <= r_byte ? {24'd0, w_rd_byte} : mem_rdata;
                        r_done  <= 1'b1;
                        r_state <= S_RESP;
                    end
                end
                S_WRITE: begin
                    r_mem_we <= 1'b0;
                    r_done   <= 1'b1;
                    r_state  <= S_RESP;
                end
                S_RESP: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_mem_we <= 1'b0;
                    r_done   <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    // Drive ports straight from the registers.
    always_comb begin
        busy      = r_busy;
        done      = r_done;
        rdata     = r_rdata;
        fault     = r_fault;
        mem_we    = r_mem_we;
        mem_addr  = r_mem_addr;
        mem_wdata = r_mem_wdata;
        dbg_state = r_state;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0;
    logic        req_we = 1'b0;
    logic        req_byte = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        fault;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [1:0]  dbg_state;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [0:63];
    logic        poke_en = 1'b0;
    logic [5:0]  poke_idx = 6'd0;
    logic [31:0] poke_val = 32'd0;

    int          done_cnt = 0;
    int          done_cyc;
    int          we_cyc;
    int          we_cnt;
    logic [7:0]  we_addr;
    logic [31:0] we_data;
    int          snap;

    load_store_unit #(.ADDR_BITS(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_we    (req_we),
        .req_byte  (req_byte),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .busy      (busy),
        .done      (done),
        .rdata     (rdata),
        .fault     (fault),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .dbg_state (dbg_state)
    );

    // clock / reset infrastructure
    always #5 clk = ~clk;

    // memory: combinational read, write on rising edge
    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
        else if (poke_en) mem[poke_idx] <= poke_val;
    end

    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [5:0] idx, input logic [31:0] val);
        @(negedge clk);
        poke_en  = 1'b1;
        poke_idx = idx;
        poke_val = val;
        @(posedge clk);
        #1 poke_en = 1'b0;
    endtask

    // Issue one request and watch up to 8 cycles for mem_we and done.
    task automatic do_req(input logic we, input logic bt, input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        req = 1'b1; req_we = we; req_byte = bt; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        done_cyc = 0; we_cyc = 0; we_cnt = 0; we_addr = 8'd0; we_data = 32'd0;
        for (int c = 1; c <= 8; c++) begin
            if (mem_we) begin
                if (we_cnt == 0) begin
                    we_cyc  = c;
                    we_addr = mem_addr;
                    we_data = mem_wdata;
                end
                we_cnt++;
            end
            if (done) begin
                done_cyc = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        // reset state
        #1 reset = 1'b1;
        #2;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        poke(6'd0, 32'hE3A01A02);
        poke(6'd1, 32'hDEADBEEF);
        poke(6'd2, 32'h00000000);
        @(negedge clk);
        reset = 1'b0;

        // word store then load
        do_req(1'b1, 1'b0, 32'h08, 32'h1AFFFFF9);
        chk("str_done_cyc", done_cyc, 2);
        chk("str_we_cyc", we_cyc, 1);
        chk("str_we_cnt", we_cnt, 1);
        chk("str_we_addr", {24'd0, we_addr}, 32'h08);
        chk("str_we_data", we_data, 32'h1AFFFFF9);
        chk("str_fault", {31'd0, fault}, 32'd0);
        do_req(1'b0, 1'b0, 32'h08, 32'd0);
        chk("ldr_done_cyc", done_cyc, 2);
        chk("ldr_rdata", rdata, 32'h1AFFFFF9);
        chk("ldr_fault", {31'd0, fault}, 32'd0);
        chk("ldr_we_cnt", we_cnt, 0);

        // byte loads
        do_req(1'b0, 1'b1, 32'h01, 32'd0);
        chk("ldrb1_done_cyc", done_cyc, 2);
        chk("ldrb1_rdata", rdata, 32'h0000001A);
        do_req(1'b0, 1'b1, 32'h03, 32'd0);
        chk("ldrb3_rdata", rdata, 32'h000000E3);
        do_req(1'b0, 1'b1, 32'h00, 32'd0);
        chk("ldrb0_rdata", rdata, 32'h00000002);

        // byte store read-modify-write
        do_req(1'b1, 1'b1, 32'h02, 32'h12345655);
        chk("strb_done_cyc", done_cyc, 3);
        chk("strb_we_cyc", we_cyc, 2);
        chk("strb_we_cnt", we_cnt, 1);
        chk("strb_we_addr", {24'd0, we_addr}, 32'h00);
        chk("strb_we_data", we_data, 32'hE3551A02);
        do_req(1'b0, 1'b0, 32'h00, 32'd0);
        chk("strb_readback", rdata, 32'hE3551A02);

        // faults
        do_req(1'b0, 1'b0, 32'h06, 32'd0);
        chk("flt_ldr_done_cyc", done_cyc, 1);
        chk("flt_ldr_fault", {31'd0, fault}, 32'd1);
        chk("flt_ldr_rdata", rdata, 32'hE3551A02);
        do_req(1'b1, 1'b0, 32'h100, 32'hCAFEF00D);
        chk("flt_str_done_cyc", done_cyc, 1);
        chk("flt_str_fault", {31'd0, fault}, 32'd1);
        chk("flt_str_we_cnt", we_cnt, 0);
        do_req(1'b0, 1'b0, 32'h04, 32'd0);
        chk("flt_clear_fault", {31'd0, fault}, 32'd0);
        chk("flt_clear_rdata", rdata, 32'hDEADBEEF);

        // req while busy in WRITE of a byte store is dropped
        poke(6'd0, 32'hE3A01A02);
        snap = done_cnt;
        @(negedge clk);
        req = 1'b1; req_we = 1'b1; req_byte = 1'b1; req_addr = 32'h01; req_wdata = 32'h000000AB;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        chk("bsy_state_read", {30'd0, dbg_state}, 32'd1);
        chk("bsy_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("bsy_we", {31'd0, mem_we}, 32'd1);
        chk("bsy_wdata", mem_wdata, 32'hE3A0AB02);
        req = 1'b1; req_we = 1'b1; req_byte = 1'b0; req_addr = 32'h04; req_wdata = 32'h55555555;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        chk("bsy_done", {31'd0, done}, 32'd1);
        @(negedge clk);
        chk("bsy_idle", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        chk("bsy_done_count", done_cnt - snap, 1);
        chk("bsy_mem04", mem[1], 32'hDEADBEEF);
        chk("bsy_mem00", mem[0], 32'hE3A0AB02);

        // reset during READ of a byte store
        poke(6'd0, 32'hE3A01A02);
        snap = done_cnt;
        @(negedge clk);
        req = 1'b1; req_we = 1'b1; req_byte = 1'b1; req_addr = 32'h00; req_wdata = 32'h00000099;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        chk("rmo_state_read", {30'd0, dbg_state}, 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("rmo_busy", {31'd0, busy}, 32'd0);
        chk("rmo_we", {31'd0, mem_we}, 32'd0);
        chk("rmo_done", {31'd0, done}, 32'd0);
        chk("rmo_state", {30'd0, dbg_state}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        req = 1'b1; req_we = 1'b0; req_byte = 1'b0; req_addr = 32'h04; req_wdata = 32'd0;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        chk("rmo_req_at_release", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        chk("rmo_mem00", mem[0], 32'hE3A01A02);
        chk("rmo_no_done", done_cnt - snap, 0);
        do_req(1'b0, 1'b0, 32'h00, 32'd0);
        chk("rmo_ldr_done_cyc", done_cyc, 2);
        chk("rmo_ldr_rdata", rdata, 32'hE3A01A02);
        chk("rmo_ldr_fault", {31'd0, fault}, 32'd0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
